// File: rtl/wino_pkg.sv
// Shared widths, tile types and saturating arithmetic for the Winograd
// output path.
package wino_pkg;
    localparam int TILE_N = 6;
    localparam int IN_W   = 12;
    localparam int ACC_W  = 16;
    localparam int ADDR_W = 8;

    typedef logic signed [0:TILE_N-1][0:TILE_N-1][IN_W-1:0]  tile_in_t;
    typedef logic signed [0:TILE_N-1][0:TILE_N-1][ACC_W-1:0] tile_acc_t;

    typedef struct packed {
        tile_acc_t         tile;
        logic [ADDR_W-1:0] addr;
        logic              size_type;
    } fifo_word_t;

    typedef struct packed {
        logic             sat;
        logic [ACC_W-1:0] val;
    } sat_res_t;

    function automatic sat_res_t sat_add(input logic [ACC_W-1:0] a,
                                         input logic [IN_W-1:0]  b);
        logic [ACC_W:0] s;
        sat_res_t       r;
        s = {a[ACC_W-1], a} + {{(ACC_W+1-IN_W){b[IN_W-1]}}, b};
        r.sat = (s[ACC_W] != s[ACC_W-1]);
        if (!r.sat)
            r.val = s[ACC_W-1:0];
        else if (s[ACC_W])
            r.val = {1'b1, {(ACC_W-1){1'b0}}};
        else
            r.val = {1'b0, {(ACC_W-1){1'b1}}};
        return r;
    endfunction
endpackage

// File: rtl/tile_accumulator_if.sv
// PE result input, completed-tile output stream and status of the
// tile accumulator.
interface tile_accumulator_if;
    import wino_pkg::*;

    tile_in_t          result_tile_i;
    logic [ADDR_W-1:0] result_address_i;
    logic              result_valid_i;
    logic              size_type_i;
    logic [4:0]        num_id_i;
    logic              clear_i;
    tile_acc_t         out_tile_o;
    logic [ADDR_W-1:0] out_address_o;
    logic              out_size_type_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              busy_o;
    logic              overflow_err_o;
    logic              sat_err_o;

    modport master (
        output result_tile_i, result_address_i, result_valid_i, size_type_i,
               num_id_i, clear_i, out_ready_i,
        input  out_tile_o, out_address_o, out_size_type_o, out_valid_o,
               busy_o, overflow_err_o, sat_err_o
    );

    modport slave (
        input  result_tile_i, result_address_i, result_valid_i, size_type_i,
               num_id_i, clear_i, out_ready_i,
        output out_tile_o, out_address_o, out_size_type_o, out_valid_o,
               busy_o, overflow_err_o, sat_err_o
    );
endinterface

// File: rtl/tile_fifo.sv
// Valid/ready FIFO of completed tiles; full/empty from the pointer MSB.
// A push into a full FIFO is dropped and recorded unless a pop frees a slot.
module tile_fifo
    import wino_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_push,
    input  fifo_word_t i_data,
    input  logic       i_ready,
    output logic       o_valid,
    output fifo_word_t o_data,
    output logic       o_overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    fifo_word_t     r_mem [DEPTH];
    logic [PTR_W:0] r_wr;
    logic [PTR_W:0] r_rd;
    logic           r_overflow;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_wr_en;

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[PTR_W] != r_rd[PTR_W]) &&
                     (r_wr[PTR_W-1:0] == r_rd[PTR_W-1:0]);
    assign w_pop   = !w_empty && i_ready;
    assign w_wr_en = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop)
                r_rd <= r_rd + (PTR_W+1)'(1);
            if (w_wr_en)
                r_wr <= r_wr + (PTR_W+1)'(1);
            if (i_push && !w_wr_en)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr[PTR_W-1:0]] <= i_data;
    end

    // Head is forced to zero while empty so outputs read 0 after reset/clear.
    assign o_valid    = !w_empty;
    assign o_data     = w_empty ? '0 : r_mem[r_rd[PTR_W-1:0]];
    assign o_overflow = r_overflow;
endmodule

// File: rtl/tile_accumulator.sv
// Accumulates PE partial tiles per address across input channels and
// queues each finished tile toward the output-memory writer.
module tile_accumulator
    import wino_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    tile_accumulator_if.slave bus
);
    logic [4:0]        r_cnt   [DEPTH];
    tile_acc_t         r_entry [DEPTH];
    logic              r_s1_valid;
    tile_in_t          r_s1_tile;
    logic [ADDR_W-1:0] r_s1_addr;
    logic              r_s1_size;
    logic              r_sat_err;

    logic [4:0]        w_target;
    logic [4:0]        w_cnt;
    tile_acc_t         w_base;
    tile_acc_t         w_sum;
    logic [IN_W-1:0]   w_add;
    sat_res_t          w_res;
    logic              w_sat;
    logic              w_done;
    logic              w_push;
    logic              w_any_cnt;
    fifo_word_t        w_push_word;
    fifo_word_t        w_head;
    logic              w_fifo_valid;
    logic              w_overflow;

    // A zero count marks the stored entry as empty, so flushing only has to
    // touch the counts, never the tile storage.
    always_comb begin
        w_target = (bus.num_id_i == 5'd0) ? 5'd1 : bus.num_id_i;
        w_cnt    = r_cnt[r_s1_addr];
        w_base   = (w_cnt == 5'd0) ? '0 : r_entry[r_s1_addr];
        w_sum    = '0;
        w_sat    = 1'b0;
        w_add    = '0;
        w_res    = '0;
        for (int i = 0; i < TILE_N; i++) begin
            for (int j = 0; j < TILE_N; j++) begin
                w_add = (r_s1_size && (i > 3 || j > 3)) ? '0 : r_s1_tile[i][j];
                w_res = sat_add(w_base[i][j], w_add);
                w_sum[i][j] = w_res.val;
                w_sat = w_sat | w_res.sat;
            end
        end
        w_done = r_s1_valid && (({1'b0, w_cnt} + 6'd1) == {1'b0, w_target});
        w_push = w_done && !bus.clear_i;
    end

    always_comb begin
        w_any_cnt = 1'b0;
        for (int d = 0; d < DEPTH; d++)
            w_any_cnt = w_any_cnt | (r_cnt[d] != 5'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_tile  <= '0;
            r_s1_addr  <= '0;
            r_s1_size  <= 1'b0;
            r_sat_err  <= 1'b0;
            for (int d = 0; d < DEPTH; d++)
                r_cnt[d] <= '0;
        end else if (bus.clear_i) begin
            r_s1_valid <= 1'b0;
            r_s1_tile  <= '0;
            r_s1_addr  <= '0;
            r_s1_size  <= 1'b0;
            r_sat_err  <= 1'b0;
            for (int d = 0; d < DEPTH; d++)
                r_cnt[d] <= '0;
        end else begin
            r_s1_valid <= bus.result_valid_i;
            r_s1_tile  <= bus.result_valid_i ? bus.result_tile_i : '0;
            r_s1_addr  <= bus.result_address_i;
            r_s1_size  <= bus.size_type_i;
            if (r_s1_valid) begin
                r_cnt[r_s1_addr] <= w_done ? 5'd0 : w_cnt + 5'd1;
                if (w_sat)
                    r_sat_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_s1_valid && !w_done)
            r_entry[r_s1_addr] <= w_sum;
    end

    assign w_push_word = '{tile: w_sum, addr: r_s1_addr, size_type: r_s1_size};

    tile_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (bus.clear_i),
        .i_push     (w_push),
        .i_data     (w_push_word),
        .i_ready    (bus.out_ready_i),
        .o_valid    (w_fifo_valid),
        .o_data     (w_head),
        .o_overflow (w_overflow)
    );

    assign bus.out_tile_o      = w_head.tile;
    assign bus.out_address_o   = w_head.addr;
    assign bus.out_size_type_o = w_head.size_type;
    assign bus.out_valid_o     = w_fifo_valid;
    assign bus.busy_o          = w_any_cnt || w_fifo_valid || r_s1_valid;
    assign bus.overflow_err_o  = w_overflow;
    assign bus.sat_err_o       = r_sat_err;
endmodule

// File: tb/tb_tile_accumulator.sv
// Bench for tile_accumulator: vector table plus hand sequences, with a
// scoreboard of expected completed tiles checked as the DUT emits them.
module tb_tile_accumulator;
    import wino_pkg::*;

    typedef struct {
        int n;
        int addr;
        bit size;
        int val;
        bit ramp;
        bit push;
        int exp_val;
        int exp_ramp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    int         total = 0;
    int         bad = 0;
    fifo_word_t sb[$];
    fifo_word_t mon_exp;
    vec_t       vecs[17];
    int         cur_n;

    tile_accumulator_if bus();

    tile_accumulator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic fifo_word_t mk(input int val, input int rm, input bit size, input int addr);
        fifo_word_t e;
        e = '0;
        for (int i = 0; i < TILE_N; i++)
            for (int j = 0; j < TILE_N; j++)
                e.tile[i][j] = (size && (i > 3 || j > 3)) ? '0 : ACC_W'(val + rm * (i * TILE_N + j));
        e.addr = ADDR_W'(addr);
        e.size_type = size;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic set_tile(input int addr, input int val, input bit ramp, input bit size);
        tile_in_t t;
        for (int i = 0; i < TILE_N; i++)
            for (int j = 0; j < TILE_N; j++)
                t[i][j] = IN_W'(val + (ramp ? i * TILE_N + j : 0));
        bus.result_tile_i    = t;
        bus.result_address_i = ADDR_W'(addr);
        bus.size_type_i      = size;
    endtask

    task automatic send(input int addr, input int val, input bit ramp, input bit size);
        set_tile(addr, val, ramp, size);
        bus.result_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.result_valid_i = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (bus.busy_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (bus.busy_o) begin
            bad++;
            $display("FAIL %s: busy_o still 1 after %0d cycles, want 0", name, k);
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (reset && bus.out_valid_o && bus.out_ready_i) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got tile at addr %0d, want no output", bus.out_address_o);
            end else begin
                mon_exp = sb.pop_front();
                if (bus.out_tile_o !== mon_exp.tile || bus.out_address_o !== mon_exp.addr ||
                    bus.out_size_type_o !== mon_exp.size_type) begin
                    bad++;
                    $display("FAIL out_word: got addr=%0d size=%0d want addr=%0d size=%0d",
                             bus.out_address_o, bus.out_size_type_o, mon_exp.addr, mon_exp.size_type);
                    for (int i = 0; i < TILE_N; i++)
                        for (int j = 0; j < TILE_N; j++)
                            if (bus.out_tile_o[i][j] !== mon_exp.tile[i][j])
                                $display("  elem[%0d][%0d] got %0d want %0d", i, j,
                                         $signed(bus.out_tile_o[i][j]), $signed(mon_exp.tile[i][j]));
                end
            end
        end
    end

    initial begin
        vecs[0]  = '{1, 3,   1'b0, 5,    1'b0, 1'b1, 5,    0};
        vecs[1]  = '{3, 9,   1'b0, 10,   1'b0, 1'b0, 0,    0};
        vecs[2]  = '{3, 9,   1'b0, -4,   1'b0, 1'b0, 0,    0};
        vecs[3]  = '{3, 9,   1'b0, 7,    1'b0, 1'b1, 13,   0};
        vecs[4]  = '{2, 0,   1'b1, 100,  1'b0, 1'b0, 0,    0};
        vecs[5]  = '{2, 0,   1'b1, 100,  1'b0, 1'b1, 200,  0};
        vecs[6]  = '{4, 1,   1'b0, 2047, 1'b0, 1'b0, 0,    0};
        vecs[7]  = '{4, 1,   1'b0, 2047, 1'b0, 1'b0, 0,    0};
        vecs[8]  = '{4, 1,   1'b0, 2047, 1'b0, 1'b0, 0,    0};
        vecs[9]  = '{4, 1,   1'b0, 2047, 1'b0, 1'b1, 8188, 0};
        vecs[10] = '{2, 200, 1'b0, 1,    1'b1, 1'b0, 0,    0};
        vecs[11] = '{2, 200, 1'b0, -3,   1'b1, 1'b1, -2,   2};
        vecs[12] = '{2, 5,   1'b0, 1,    1'b0, 1'b0, 0,    0};
        vecs[13] = '{2, 6,   1'b0, 2,    1'b0, 1'b0, 0,    0};
        vecs[14] = '{2, 5,   1'b0, 3,    1'b0, 1'b1, 4,    0};
        vecs[15] = '{2, 6,   1'b0, 4,    1'b0, 1'b1, 6,    0};
        vecs[16] = '{0, 77,  1'b0, -9,   1'b0, 1'b1, -9,   0};

        reset                = 1'b0;
        bus.result_tile_i    = '0;
        bus.result_address_i = '0;
        bus.result_valid_i   = 1'b0;
        bus.size_type_i      = 1'b0;
        bus.num_id_i         = 5'd1;
        bus.clear_i          = 1'b0;
        bus.out_ready_i      = 1'b1;

        #12;
        chk("rst_valid", bus.out_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_ovf", bus.overflow_err_o, 0);
        chk("rst_sat", bus.sat_err_o, 0);
        total++;
        if (bus.out_tile_o !== '0) begin
            bad++;
            $display("FAIL rst_tile: got nonzero tile, want all 0");
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Single completion latency: out_valid_o rises in cycle t+2.
        bus.num_id_i = 5'd1;
        sb.push_back(mk(5, 0, 1'b0, 3));
        set_tile(3, 5, 1'b0, 1'b0);
        bus.result_valid_i = 1'b1;
        @(negedge clk);
        chk("lat_t0", bus.out_valid_o, 0);
        @(posedge clk); #1;
        bus.result_valid_i = 1'b0;
        @(negedge clk);
        chk("lat_t1", bus.out_valid_o, 0);
        @(negedge clk);
        chk("lat_t2", bus.out_valid_o, 1);
        wait_idle("busy_after_single");

        cur_n = -1;
        for (int v = 0; v < 17; v++) begin
            if (vecs[v].n != cur_n) begin
                wait_idle("idle_before_num_id");
                bus.num_id_i = 5'(vecs[v].n);
                cur_n = vecs[v].n;
            end
            if (vecs[v].push)
                sb.push_back(mk(vecs[v].exp_val, vecs[v].exp_ramp, vecs[v].size, vecs[v].addr));
            send(vecs[v].addr, vecs[v].val, vecs[v].ramp, vecs[v].size);
        end
        wait_idle("table_drain");
        chk("table_sb_empty", sb.size(), 0);
        chk("table_no_sat", bus.sat_err_o, 0);
        chk("table_no_ovf", bus.overflow_err_o, 0);

        // Saturation: 17 contributions of 2047 exceed the positive range.
        bus.num_id_i = 5'd17;
        repeat (16) send(50, 2047, 1'b0, 1'b0);
        tick(2);
        chk("sat_before", bus.sat_err_o, 0);
        chk("sat_no_early_out", bus.out_valid_o, 0);
        sb.push_back(mk(32767, 0, 1'b0, 50));
        send(50, 2047, 1'b0, 1'b0);
        wait_idle("sat_drain");
        chk("sat_after", bus.sat_err_o, 1);
        chk("sat_sb_empty", sb.size(), 0);

        // Push into a full FIFO on the same edge as a pop.
        bus.num_id_i = 5'd1;
        bus.out_ready_i = 1'b0;
        for (int a = 0; a < 4; a++) begin
            sb.push_back(mk(a + 1, 0, 1'b0, 10 + a));
            send(10 + a, a + 1, 1'b0, 1'b0);
        end
        tick(3);
        chk("full_valid", bus.out_valid_o, 1);
        chk("full_head_addr", bus.out_address_o, 10);
        sb.push_back(mk(5, 0, 1'b0, 14));
        set_tile(14, 5, 1'b0, 1'b0);
        bus.result_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.result_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        wait_idle("pushpop_drain");
        chk("pushpop_no_ovf", bus.overflow_err_o, 0);
        chk("pushpop_sb_empty", sb.size(), 0);

        // Overflow: six completions into a 4-deep FIFO with no consumer.
        bus.out_ready_i = 1'b0;
        for (int a = 0; a < 4; a++) begin
            sb.push_back(mk(20 + a, 0, 1'b0, a));
            send(a, 20 + a, 1'b0, 1'b0);
        end
        tick(3);
        chk("ovf_before", bus.overflow_err_o, 0);
        chk("hold_addr0", bus.out_address_o, 0);
        chk("hold_t00_0", bus.out_tile_o[0][0], 20);
        send(4, 24, 1'b0, 1'b0);
        send(5, 25, 1'b0, 1'b0);
        tick(3);
        chk("ovf_after", bus.overflow_err_o, 1);
        chk("hold_addr1", bus.out_address_o, 0);
        chk("hold_t00_1", bus.out_tile_o[0][0], 20);
        bus.out_ready_i = 1'b1;
        wait_idle("ovf_drain");
        chk("ovf_sb_empty", sb.size(), 0);
        chk("ovf_sticky", bus.overflow_err_o, 1);

        // clear_i discards the in-flight tile and the error flags.
        bus.num_id_i = 5'd2;
        send(7, 50, 1'b0, 1'b0);
        bus.clear_i = 1'b1;
        @(posedge clk); #1;
        bus.clear_i = 1'b0;
        send(7, 60, 1'b0, 1'b0);
        tick(3);
        chk("clr_no_out", bus.out_valid_o, 0);
        chk("clr_ovf", bus.overflow_err_o, 0);
        chk("clr_sat", bus.sat_err_o, 0);
        chk("clr_busy_pending", bus.busy_o, 1);
        sb.push_back(mk(61, 0, 1'b0, 7));
        send(7, 1, 1'b0, 1'b0);
        wait_idle("clr_drain");
        chk("clr_sb_empty", sb.size(), 0);

        // Asynchronous reset with a full FIFO and a sticky overflow.
        bus.num_id_i = 5'd1;
        bus.out_ready_i = 1'b0;
        for (int a = 0; a < 5; a++)
            send(30 + a, a, 1'b0, 1'b0);
        tick(3);
        chk("pre_rst_valid", bus.out_valid_o, 1);
        chk("pre_rst_ovf", bus.overflow_err_o, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid_o, 0);
        chk("mid_rst_busy", bus.busy_o, 0);
        chk("mid_rst_ovf", bus.overflow_err_o, 0);
        chk("mid_rst_addr", bus.out_address_o, 0);
        total++;
        if (bus.out_tile_o !== '0) begin
            bad++;
            $display("FAIL mid_rst_tile: got nonzero tile, want all 0");
        end
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready_i = 1'b1;
        tick(3);
        chk("post_rst_valid", bus.out_valid_o, 0);
        chk("post_rst_busy", bus.busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
